// File: rtl/pp_sum_pkg.sv
// Shared types and width helpers for the partial-product sum accumulator.
package pp_sum_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    OUT     = 2'd3
  } state_t;

  // Internal datapath width: full product width plus guard bits for the sum.
  function automatic int data_w(input int length);
    return 2 * length + 4;
  endfunction

  // Width of a counter that must represent 0..max_pp inclusive.
  function automatic int cnt_w(input int max_pp);
    return $clog2(max_pp + 1);
  endfunction

endpackage

// File: rtl/csa_3to2.sv
// Combinational 3:2 carry-save compressor. The carry vector comes out already
// shifted up one place, with ci filling the freed bit 0; the majority bit of
// the top position is dropped because the sum is taken modulo 2^WIDTH.
module csa_3to2 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             ci,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
);

  // Bitwise full-adder: parity to sum, majority (shifted) to carry.
  assign sum   = a ^ b ^ c;
  assign carry = {(a[WIDTH-2:0] & b[WIDTH-2:0]) |
                  (a[WIDTH-2:0] & c[WIDTH-2:0]) |
                  (b[WIDTH-2:0] & c[WIDTH-2:0]), ci};

endmodule

// File: rtl/pp_sum_accum.sv
// Accumulates a stream of partial products in carry-save form and resolves
// the final sum with a single carry-propagate add once the transaction ends.
module pp_sum_accum
  import pp_sum_pkg::*;
#(
  parameter  int LENGTH = 32,
  parameter  int MAX_PP = 9,
  localparam int W      = data_w(LENGTH),
  localparam int CW     = cnt_w(MAX_PP)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_pp,
  input  logic          in_ci,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_sum,
  output logic          out_co,
  output logic [CW-1:0] out_cnt,
  output logic          err_ovf
);

  state_t        state;
  logic [W:0]    s_q;
  logic [W:0]    c_q;
  logic [CW-1:0] cnt_q;
  logic          ovf_q;

  logic [W:0]    pp_ext;
  logic [W:0]    csa_sum;
  logic [W:0]    csa_carry;
  logic [W:0]    total;
  logic [CW-1:0] cnt_nxt;
  logic          accept;
  logic          at_max;

  assign pp_ext = {1'b0, in_pp};

  csa_3to2 #(
    .WIDTH (W + 1)
  ) u_csa (
    .a     (s_q),
    .b     (c_q),
    .c     (pp_ext),
    .ci    (in_ci),
    .sum   (csa_sum),
    .carry (csa_carry)
  );

  // Beats are only taken while a transaction is open or about to open.
  assign in_ready = (state == IDLE) || (state == ACCUM);
  assign accept   = in_valid && in_ready;
  assign cnt_nxt  = (state == IDLE) ? CW'(1) : cnt_q + 1'b1;
  assign at_max   = (cnt_nxt == CW'(MAX_PP));

  // The one carry-propagate adder, consumed only in RESOLVE.
  assign total = s_q + c_q;

  // Control FSM plus carry-save state and registered result outputs.
  // NOTE: every register here uses non-blocking assignment so all state
  // updates see the pre-edge values, exactly like the hardware flops do.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      s_q       <= '0;
      c_q       <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_sum   <= '0;
      out_co    <= 1'b0;
      out_cnt   <= '0;
      err_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            if (state == IDLE) begin
              s_q <= pp_ext;
              c_q <= {{W{1'b0}}, in_ci};
            end else begin
              s_q <= csa_sum;
              c_q <= csa_carry;
            end
            cnt_q <= cnt_nxt;
            if (in_last || at_max) begin
              // Hitting the beat limit without in_last means the stream was cut.
              ovf_q <= !in_last;
              state <= RESOLVE;
            end else begin
              state <= ACCUM;
            end
          end
        end
        RESOLVE: begin
          out_sum <= total[W-1:0];
          out_co  <= total[W];
          out_cnt <= cnt_q;
          err_ovf <= ovf_q;
          state   <= OUT;
        end
        OUT: begin
          // out_valid rises one cycle after the result registers load,
          // then holds until the consumer takes it.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pp_sum_accum.sv
// Directed bench for pp_sum_accum with hand-computed expected results.
module tb_pp_sum_accum;
  import pp_sum_pkg::*;

  localparam int LENGTH = 32;
  localparam int MAX_PP = 9;
  localparam int W      = data_w(LENGTH);
  localparam int CW     = cnt_w(MAX_PP);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_pp;
  logic          in_ci;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic          out_co;
  logic [CW-1:0] out_cnt;
  logic          err_ovf;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] all_ones;

  pp_sum_accum #(
    .LENGTH (LENGTH),
    .MAX_PP (MAX_PP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pp     (in_pp),
    .in_ci     (in_ci),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_co    (out_co),
    .out_cnt   (out_cnt),
    .err_ovf   (err_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat is taken.
  task automatic send_beat(input logic [W-1:0] pp, input logic ci, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_pp    = pp;
    in_ci    = ci;
    in_last  = last;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("beat_accept", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, out_valid, 1);
  endtask

  task automatic take_result(input string tag, input logic [W-1:0] sum, input logic co,
                             input logic [CW-1:0] cnt, input logic ovf);
    wait_valid(tag);
    check({tag, "_sum"}, out_sum, sum);
    check({tag, "_co"}, out_co, co);
    check({tag, "_cnt"}, out_cnt, cnt);
    check({tag, "_ovf"}, err_ovf, ovf);
    check({tag, "_inrdy_out"}, in_ready, 0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_inrdy_after"}, in_ready, 1);
  endtask

  initial begin
    all_ones  = '1;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_pp     = '0;
    in_ci     = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_cnt", out_cnt, 0);
    check("rst_err_ovf", err_ovf, 0);

    // 5 + 7 + 9 + ci(1) = 22, with exact two-edge latency.
    send_beat(W'(5), 1'b0, 1'b0);
    send_beat(W'(7), 1'b1, 1'b0);
    send_beat(W'(9), 1'b0, 1'b1);
    check("lat_t0", out_valid, 0);
    @(negedge clk);
    check("lat_t1", out_valid, 0);
    @(negedge clk);
    check("lat_t2", out_valid, 1);
    take_result("basic", W'(22), 1'b0, CW'(3), 1'b0);

    // Input stall mid-transaction holds state: 100 + 200 + 1 = 301.
    send_beat(W'(100), 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("stall_in_ready", in_ready, 1);
    check("stall_no_valid", out_valid, 0);
    send_beat(W'(200), 1'b1, 1'b1);
    take_result("stall", W'(301), 1'b0, CW'(2), 1'b0);

    // (2^W - 1) + 1 = 2^W: sum wraps to zero with carry-out.
    send_beat(all_ones, 1'b1, 1'b1);
    take_result("ones", W'(0), 1'b1, CW'(1), 1'b0);

    // (2^W - 3) + 5 = 2^W + 2, held under output backpressure.
    send_beat(all_ones - W'(2), 1'b0, 1'b0);
    send_beat(W'(5), 1'b0, 1'b1);
    wait_valid("bp");
    for (int i = 0; i < 4; i++) begin
      check("bp_hold_sum", out_sum, 2);
      check("bp_hold_co", out_co, 1);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_in_ready", in_ready, 0);
      @(negedge clk);
    end
    take_result("bp", W'(2), 1'b1, CW'(2), 1'b0);

    // Ten beats without in_last: first nine truncate with err_ovf, the tenth
    // waits through the handshake and opens a new transaction.
    for (int i = 0; i < 9; i++) send_beat(W'(1), 1'b0, 1'b0);
    fork
      send_beat(W'(1), 1'b0, 1'b0);
      take_result("ovf", W'(9), 1'b0, CW'(9), 1'b1);
    join
    send_beat(W'(1), 1'b0, 1'b1);
    take_result("after_ovf", W'(2), 1'b0, CW'(2), 1'b0);

    // Reset mid-ACCUM discards the transaction.
    send_beat(W'(1), 1'b0, 1'b0);
    send_beat(W'(2), 1'b0, 1'b0);
    send_beat(W'(3), 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_in_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      check("mid_rst_no_valid", out_valid, 0);
      @(negedge clk);
    end
    send_beat(W'(4), 1'b0, 1'b0);
    send_beat(W'(6), 1'b1, 1'b1);
    take_result("post_rst", W'(11), 1'b0, CW'(2), 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pp_sum_accum.md
PP_SUM_ACCUM -- requirements
Module: pp_sum_accum

Interface
REQ-001 SHALL have parameter LENGTH, default 32, the multiplicand width; internal data width W = 2*LENGTH+4.
REQ-002 SHALL have parameter MAX_PP, default 9, the maximum number of partial-product beats per transaction.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  partial-product beat present.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 in_pp  input  W  partial product, already shifted and sign-extended.
REQ-009 in_ci  input  1  per-beat carry/sign-correction bit, weight 2^0.
REQ-010 in_last  input  1  final beat of the transaction.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 out_sum  output  W  result bits [W-1:0].
REQ-014 out_co  output  1  result bit W.
REQ-015 out_cnt  output  clog2(MAX_PP+1)  number of beats summed.
REQ-016 err_ovf  output  1  transaction was truncated at MAX_PP beats; valid with out_valid.

Function
REQ-017 SHALL define the result as (sum of all in_pp + sum of all in_ci) mod 2^(W+1), with out_sum = bits [W-1:0] and out_co = bit W.
REQ-018 SHALL hold carry-save registers S and C, each W+1 bits, and a beat counter.
REQ-019 SHALL implement states IDLE, ACCUM, RESOLVE, OUT.
REQ-020 SHALL assert in_ready in IDLE and ACCUM only; a beat is accepted when in_valid and in_ready are both high.
REQ-021 On a beat accepted in IDLE: S <= zero-extended in_pp; C <= in_ci in bit 0, with all other bits zero; count <= 1.
REQ-022 On a beat accepted in ACCUM: S <= S^C^pp; C <= {maj(S,C,pp)[W-1:0], in_ci}; count increments.
REQ-023 Transitions: on an accepted beat with in_last low and count+1 < MAX_PP, go to ACCUM; on in_last high, or when count reaches MAX_PP, go to RESOLVE.
REQ-024 err_ovf SHALL be set when the MAX_PP-th beat has in_last low; the next beat starts a new transaction.
REQ-025 RESOLVE SHALL take one cycle: register S+C into the output registers, then go to OUT.
REQ-026 Latency: last beat accepted at edge t means out_valid is high after edge t+2.
REQ-027 In OUT: out_valid is high; out_sum, out_co, out_cnt and err_ovf are held stable until out_ready; on the handshake go to IDLE.
REQ-028 A beat SHALL NOT be accepted in the same cycle as the output handshake; in_ready rises in the cycle after it.
REQ-029 in_valid stalls in ACCUM SHALL hold S, C and count unchanged, with no timeout.

Reset
REQ-030 rst SHALL force IDLE and clear S, C, count, out_sum, out_co, out_cnt, err_ovf and out_valid; in_ready reads 1 in the first cycle after reset.
REQ-031 Reset during ACCUM, RESOLVE or OUT SHALL discard the transaction without emitting a result.

Structure
REQ-032 Package pp_sum_pkg SHALL hold the state enum, a width function W(LENGTH), and the count-width function.
REQ-033 The 3:2 compression SHALL be a combinational sub-module csa_3to2, parameterised on width.
REQ-034 The carry-propagate add SHALL be behavioural, with a single CPA in RESOLVE.

Verification
REQ-035 LENGTH=32: beats 5/ci0, 7/ci1, 9/ci0 with last on the third beat -> out_sum=22, out_co=0, out_cnt=3, err_ovf=0, out_valid two cycles after the last beat.
REQ-036 Single beat in_pp=all-ones(W), in_ci=1, in_last=1 -> out_sum=0, out_co=1, out_cnt=1.
REQ-037 Beats 2^W-3 and 5 -> out_sum=2, out_co=1; with out_ready low for 4 cycles, outputs are stable and in_ready=0 throughout.
REQ-038 MAX_PP=9: send 10 beats of value 1, all with in_last=0 -> first result out_sum=9, out_cnt=9, err_ovf=1; the 10th beat is accepted after the handshake and starts a new transaction.
REQ-039 Assert rst for one cycle mid-ACCUM after 3 beats -> no out_valid, in_ready=1 the next cycle, and the following transaction sums correctly from zero.
